// File: rtl/hsid_mse.sv
// Mean squared error of one pixel vector against one library reference, with a serial restoring divider.
// Optional round-half-up of the quotient is enabled by defining HSID_MSE_ROUND_EN.
module hsid_mse #(
  parameter int WORD_WIDTH       = 32,
  parameter int HSI_BAND_WIDTH   = 16,
  parameter int HSI_MAX_BANDS    = 128,
  parameter int HSI_LIBRARY_SIZE = 4096,
  localparam int REF_W     = $clog2(HSI_LIBRARY_SIZE),
  localparam int ACC_WIDTH = 2*HSI_BAND_WIDTH + $clog2(HSI_MAX_BANDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      element_valid,
  output logic                      element_ready,
  input  logic                      element_last,
  input  logic [HSI_BAND_WIDTH-1:0] element_a,
  input  logic [HSI_BAND_WIDTH-1:0] element_b,
  input  logic [REF_W-1:0]          hsp_ref,
  output logic                      mse_out_valid,
  output logic [WORD_WIDTH-1:0]     mse_value,
  output logic [REF_W-1:0]          mse_ref,
  output logic                      busy,
  output logic                      error
);

  localparam int BW    = HSI_BAND_WIDTH;
  localparam int CNT_W = $clog2(HSI_MAX_BANDS) + 1;
`ifdef HSID_MSE_ROUND_EN
  localparam int DIV_W = ACC_WIDTH + 1;
`else
  localparam int DIV_W = ACC_WIDTH;
`endif
  localparam int STEP_W = $clog2(DIV_W + 1);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, DIV, OUT} state_t;

  state_t                 state_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [2*BW-1:0]        sq_reg;
  logic                   sq_valid_reg;
  logic [REF_W-1:0]       ref_reg;
  logic                   drain_reg;
  logic                   discard_reg;
  logic [DIV_W-1:0]       dvd_reg;
  logic [CNT_W-1:0]       rem_reg;
  logic [STEP_W-1:0]      step_reg;

  logic                   accept;
  logic [BW:0]            diff_ab;
  logic [BW:0]            diff_ba;
  logic [BW-1:0]          mag;
  logic [2*BW-1:0]        mag_w;
  logic [2*BW-1:0]        sq_next;
  logic [CNT_W:0]         shifted;
  logic [CNT_W:0]         sub;
  logic                   fits;
  logic [CNT_W-1:0]       rem_next;
  logic [DIV_W-1:0]       dividend;

  assign element_ready = (state_reg == IDLE) || (state_reg == ACC);
  assign busy          = (state_reg != IDLE);
  assign accept        = element_valid && element_ready;

  // |a-b| squared equals (a-b)^2 and avoids a signed multiplier
  assign diff_ab = {1'b0, element_a} - {1'b0, element_b};
  assign diff_ba = {1'b0, element_b} - {1'b0, element_a};
  assign mag     = diff_ab[BW] ? diff_ba[BW-1:0] : diff_ab[BW-1:0];
  assign mag_w   = {{BW{1'b0}}, mag};
  assign sq_next = mag_w * mag_w;

  // One restoring-division step: the remainder never exceeds the band count
  assign shifted  = {rem_reg, dvd_reg[DIV_W-1]};
  assign sub      = shifted - {1'b0, count_reg};
  assign fits     = (shifted >= {1'b0, count_reg});
  assign rem_next = fits ? sub[CNT_W-1:0] : shifted[CNT_W-1:0];

`ifdef HSID_MSE_ROUND_EN
  assign dividend = {1'b0, acc_reg} + {{(DIV_W-CNT_W){1'b0}}, count_reg >> 1};
`else
  assign dividend = acc_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      sq_reg        <= '0;
      sq_valid_reg  <= 1'b0;
      ref_reg       <= '0;
      drain_reg     <= 1'b0;
      discard_reg   <= 1'b0;
      dvd_reg       <= '0;
      rem_reg       <= '0;
      step_reg      <= '0;
      mse_out_valid <= 1'b0;
      mse_value     <= '0;
      mse_ref       <= '0;
      error         <= 1'b0;
    end else if (clear) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      sq_reg        <= '0;
      sq_valid_reg  <= 1'b0;
      drain_reg     <= 1'b0;
      discard_reg   <= 1'b0;
      mse_out_valid <= 1'b0;
      error         <= 1'b0;
    end else begin
      mse_out_valid <= 1'b0;
      sq_valid_reg  <= accept;
      if (accept) sq_reg <= sq_next;
      if (sq_valid_reg) acc_reg <= acc_reg + {{(ACC_WIDTH-2*BW){1'b0}}, sq_reg};

      case (state_reg)
        IDLE: begin
          if (accept) begin
            ref_reg     <= hsp_ref;
            count_reg   <= CNT_W'(1);
            drain_reg   <= 1'b0;
            discard_reg <= 1'b0;
            state_reg   <= element_last ? DRAIN : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            count_reg <= count_reg + CNT_W'(1);
            drain_reg <= 1'b0;
            if (element_last) begin
              state_reg <= DRAIN;
            end else if (count_reg == CNT_W'(HSI_MAX_BANDS)) begin
              error       <= 1'b1;
              discard_reg <= 1'b1;
              state_reg   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drain_reg <= 1'b1;
          if (drain_reg) begin
            if (discard_reg) begin
              state_reg <= IDLE;
              acc_reg   <= '0;
              count_reg <= '0;
            end else begin
              state_reg <= DIV;
              dvd_reg   <= dividend;
              rem_reg   <= '0;
              step_reg  <= '0;
            end
          end
        end
        DIV: begin
          if (step_reg == STEP_W'(DIV_W)) begin
            state_reg     <= OUT;
            mse_out_valid <= 1'b1;
            mse_value     <= dvd_reg[WORD_WIDTH-1:0];
            mse_ref       <= ref_reg;
          end else begin
            dvd_reg  <= {dvd_reg[DIV_W-2:0], fits};
            rem_reg  <= rem_next;
            step_reg <= step_reg + STEP_W'(1);
          end
        end
        OUT: begin
          state_reg <= IDLE;
          acc_reg   <= '0;
          count_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsid_mse.sv
// Self-checking bench for hsid_mse: vector table plus scoreboard, and hand-written
// sequences for overflow, clear, mid-vector reset and back-to-back vectors.
module tb_hsid_mse;

`ifdef HSID_MSE_ROUND_EN
  localparam int  DIV_W = 40;
  localparam bit  RND   = 1'b1;
`else
  localparam int  DIV_W = 39;
  localparam bit  RND   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        element_valid = 1'b0;
  logic        element_ready;
  logic        element_last = 1'b0;
  logic [15:0] element_a = '0;
  logic [15:0] element_b = '0;
  logic [11:0] hsp_ref = '0;
  logic        mse_out_valid;
  logic [31:0] mse_value;
  logic [11:0] mse_ref;
  logic        busy;
  logic        error;

  hsid_mse dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .element_valid(element_valid), .element_ready(element_ready),
    .element_last(element_last), .element_a(element_a), .element_b(element_b),
    .hsp_ref(hsp_ref), .mse_out_valid(mse_out_valid), .mse_value(mse_value),
    .mse_ref(mse_ref), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [15:0] a [4];
    logic [15:0] b [4];
    logic [11:0] rf;
    logic [31:0] et;
    logic [31:0] er;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic [11:0] rf;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   nstrobe = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int nb,
                         input logic [15:0] a0, a1, a2, a3,
                         input logic [15:0] b0, b1, b2, b3,
                         input logic [11:0] rf, input logic [31:0] et, er);
    vecs[i].nb = nb;
    vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2; vecs[i].a[3] = a3;
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2; vecs[i].b[3] = b3;
    vecs[i].rf = rf; vecs[i].et = et; vecs[i].er = er;
  endtask

  // Cycle stamp of the edge that accepts a final pair
  always @(posedge clk) begin
    cyc++;
    if (rst_n && !clear && element_valid && element_ready && element_last) last_cyc = cyc;
  end

  always @(negedge clk) begin
    if (mse_out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {31'd0, mse_out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        nstrobe++;
        $display("strobe %0d value %0h ref %0h latency %0d", nstrobe, mse_value, mse_ref, cyc - last_cyc);
        check("mse_value", {32'd0, mse_value}, {32'd0, e.val});
        check("mse_ref", {52'd0, mse_ref}, {52'd0, e.rf});
        check("latency", 64'(cyc - last_cyc), 64'(DIV_W + 3));
      end
    end
  end

  // Drive one pair from a negedge and return after the accepting edge
  task automatic send(input logic [15:0] a, b, input logic [11:0] r, input bit last,
                      input bit hold, output int waited);
    int n;
    n = 0;
    element_valid = 1'b1; element_a = a; element_b = b; hsp_ref = r; element_last = last;
    while (!element_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    if (!hold) begin
      element_valid = 1'b0;
      element_last  = 1'b0;
    end
    waited = n;
  endtask

  // Later pairs carry a different ref to show only the first is latched
  task automatic run_vec(input int i, input bit hold_after, input bit push, output int first_wait);
    int w;
    exp_t e;
    first_wait = 0;
    for (int k = 0; k < vecs[i].nb; k++) begin
      bit last;
      last = (k == vecs[i].nb - 1);
      if (last && push) begin
        e.val = RND ? vecs[i].er : vecs[i].et;
        e.rf  = vecs[i].rf;
        sb.push_back(e);
      end
      send(vecs[i].a[k], vecs[i].b[k], (k == 0) ? vecs[i].rf : ~vecs[i].rf,
           last, hold_after || !last, w);
      if (k == 0) first_wait = w;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("strobe_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int w;
    set_vec(0, 4, 10, 20, 30, 40, 7, 23, 26, 39, 12'd5, 32'd8, 32'd9);
    set_vec(1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 12'hFFF, 32'hFFFE0001, 32'hFFFE0001);
    set_vec(2, 3, 0, 16'hFFFF, 100, 0, 16'hFFFF, 0, 100, 0, 12'd7, 32'd2863224150, 32'd2863224150);
    set_vec(3, 2, 3, 0, 0, 0, 0, 4, 0, 0, 12'd100, 32'd12, 32'd13);
    set_vec(4, 3, 1, 2, 3, 0, 0, 0, 0, 0, 12'd1, 32'd4, 32'd5);
    set_vec(5, 2, 100, 100, 0, 0, 100, 100, 0, 0, 12'd2, 32'd0, 32'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'd0, element_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_valid", {63'd0, mse_out_valid}, 64'd0);
    check("rst_value", {32'd0, mse_value}, 64'd0);
    check("rst_ref", {52'd0, mse_ref}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, 1'b0, 1'b1, w);
      wait_drain();
    end

    // Overflow: 129 pairs without last
    for (int k = 0; k < 129; k++) send(16'd1, 16'd0, 12'd9, 1'b0, k < 128, w);
    check("ovf_error_set", {63'd0, error}, 64'd1);
    repeat (5) @(negedge clk);
    check("ovf_idle", {63'd0, busy}, 64'd0);
    check("ovf_sticky", {63'd0, error}, 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("ovf_cleared", {63'd0, error}, 64'd0);

    // Clear during DIV: no strobe, result registers kept
    run_vec(1, 1'b0, 1'b1, w);
    wait_drain();
    run_vec(4, 1'b0, 1'b0, w);
    repeat (20) @(negedge clk);
    check("div_busy", {63'd0, busy}, 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_idle", {63'd0, busy}, 64'd0);
    repeat (60) @(negedge clk);
    check("clear_keep_value", {32'd0, mse_value}, 64'h0FFFE0001);
    check("clear_keep_ref", {52'd0, mse_ref}, 64'hFFF);
    run_vec(5, 1'b0, 1'b1, w);
    wait_drain();

    // Asynchronous reset mid-vector
    run_vec(1, 1'b0, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 3; k++) send(16'd50, 16'd1, 12'd3, 1'b0, 1'b1, w);
    element_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", {63'd0, element_ready}, 64'd1);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_value", {32'd0, mse_value}, 64'd0);
    check("arst_ref", {52'd0, mse_ref}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(3, 1'b0, 1'b1, w);
    wait_drain();

    // Back-to-back with element_valid held high
    run_vec(0, 1'b1, 1'b1, w);
    run_vec(2, 1'b0, 1'b1, w);
    check("b2b_ready_low", 64'(w), 64'(DIV_W + 4));
    wait_drain();
    check("strobe_count", 64'(nstrobe), 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
